reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file.sv | 66 ++++++
 tb/tb_reg_file.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the architectural register file.
// Holds the data and specifier widths, the register count and the two
// architecturally special register numbers (hard-wired zero, return value).
package reg_file_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  // r0 reads as zero and ignores writes; r1 holds the return value.
  localparam reg_addr_t ZERO_REG = 5'd0;
  localparam reg_addr_t RET_REG  = 5'd1;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 32 x 32-bit, two registered read ports and
// two write ports, with write-through bypass on reads.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_1 / d_1, s_2 / d_2           read specifier in, registered read data out
//   we1, target_1, write_data_1    write port 1 (primary result, wins on clash)
//   we2, target_2, write_data_2    write port 2 (base-register update)
//   stall                          holds d_1/d_2; writes still happen
//   ret_val                        stored contents of r1, no bypass
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        s_1,
  output logic [DATA_W-1:0] d_1,
  input  logic [4:0]        s_2,
  output logic [DATA_W-1:0] d_2,
  input  logic              we1,
  input  logic [4:0]        target_1,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic              we2,
  input  logic [4:0]        target_2,
  input  logic [DATA_W-1:0] write_data_2,
  input  logic              stall,
  output logic [DATA_W-1:0] ret_val
);

  reg_data_t regs [NREGS];

  // Value a read of register s returns at this edge: the same-cycle write
  // (port 1 over port 2) if one targets s, otherwise the stored value.
  // r0 is forced to zero regardless of any write aimed at it.
  function automatic reg_data_t read_value(input reg_addr_t s);
    reg_data_t v;
    v = regs[s];
    if (we2 && (target_2 == s)) v = write_data_2;
    if (we1 && (target_1 == s)) v = write_data_1;
    if (s == ZERO_REG)          v = '0;
    return v;
  endfunction

  // NOTE: the array is cleared on reset because architectural state must
  // start at zero; this costs a reset net on every bit, unlike a plain RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      d_1 <= '0;
      d_2 <= '0;
    end else begin
      // NOTE: non-blocking assignments; the later statement wins, which
      // gives port 1 priority when both ports target the same register.
      if (we2 && (target_2 != ZERO_REG)) regs[target_2] <= write_data_2;
      if (we1 && (target_1 != ZERO_REG)) regs[target_1] <= write_data_1;

      if (!stall) begin
        d_1 <= read_value(s_1);
        d_2 <= read_value(s_2);
      end
    end
  end

  assign ret_val = regs[RET_REG];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps from the test plan, then
// randomized traffic compared against a reference model that computes the
// post-edge register state and reads from it.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  s_1, s_2, target_1, target_2;
  logic [31:0] d_1, d_2, write_data_1, write_data_2, ret_val;
  logic        we1, we2, stall;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_d1, m_d2;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst),
    .s_1(s_1), .d_1(d_1), .s_2(s_2), .d_2(d_2),
    .we1(we1), .target_1(target_1), .write_data_1(write_data_1),
    .we2(we2), .target_2(target_2), .write_data_2(write_data_2),
    .stall(stall), .ret_val(ret_val)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0;
    we1 = 1'b0; target_1 = '0; write_data_1 = '0;
    we2 = 1'b0; target_2 = '0; write_data_2 = '0;
  endtask

  // Advance one edge: model computes the state after the edge (writes applied,
  // port 1 last so it wins, r0 stays zero), reads see that new state; then the
  // DUT is sampled 1 time unit after the edge and compared.
  task automatic cycle(input string tag);
    logic [31:0] nxt [32];
    nxt = m_regs;
    if (rst) begin
      foreach (nxt[i]) nxt[i] = '0;
      m_d1 = '0;
      m_d2 = '0;
    end else begin
      if (we2) nxt[target_2] = write_data_2;
      if (we1) nxt[target_1] = write_data_1;
      nxt[0] = '0;
      if (!stall) begin
        m_d1 = nxt[s_1];
        m_d2 = nxt[s_2];
      end
    end
    @(posedge clk);
    #1;
    m_regs = nxt;
    check({tag, " d_1"}, d_1, m_d1);
    check({tag, " d_2"}, d_2, m_d2);
    check({tag, " ret_val"}, ret_val, m_regs[1]);
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    m_d1 = '0; m_d2 = '0;
    idle();
    s_1 = '0; s_2 = '0;

    // Reset, then read r5 / r31
    @(negedge clk);
    rst = 1'b1;
    cycle("reset");
    rst = 1'b0; s_1 = 5'd5; s_2 = 5'd31;
    cycle("post-reset read");
    check("reset d_1 zero", d_1, 32'h0);
    check("reset d_2 zero", d_2, 32'h0);
    check("reset ret_val zero", ret_val, 32'h0);

    // Plain write then read
    we1 = 1'b1; target_1 = 5'd3; write_data_1 = 32'hDEADBEEF;
    cycle("write r3");
    idle(); s_1 = 5'd3;
    cycle("read r3");
    check("r3 readback", d_1, 32'hDEADBEEF);

    // Same-cycle bypass through port 2
    we2 = 1'b1; target_2 = 5'd7; write_data_2 = 32'h1234; s_2 = 5'd7;
    cycle("bypass r7");
    check("bypass d_2", d_2, 32'h1234);

    // Dual write clash: port 1 wins (both bypass and stored)
    idle();
    we1 = 1'b1; target_1 = 5'd9; write_data_1 = 32'hAAAA;
    we2 = 1'b1; target_2 = 5'd9; write_data_2 = 32'hBBBB;
    s_1 = 5'd9;
    cycle("dual write r9");
    check("dual bypass d_1", d_1, 32'hAAAA);
    idle(); s_2 = 5'd9;
    cycle("read r9");
    check("dual stored d_2", d_2, 32'hAAAA);

    // Writes to r0 are discarded
    we1 = 1'b1; target_1 = 5'd0; write_data_1 = 32'hFFFFFFFF;
    we2 = 1'b1; target_2 = 5'd0; write_data_2 = 32'hFFFFFFFF;
    s_1 = 5'd0;
    cycle("write r0");
    check("r0 bypass d_1", d_1, 32'h0);
    idle();
    cycle("read r0");
    check("r0 stored d_1", d_1, 32'h0);

    // Stall holds outputs while writes continue
    we1 = 1'b1; target_1 = 5'd4; write_data_1 = 32'h10;
    cycle("write r4");
    idle(); s_1 = 5'd4;
    cycle("read r4");
    check("r4 pre-stall", d_1, 32'h10);
    stall = 1'b1; we1 = 1'b1; target_1 = 5'd4; write_data_1 = 32'h20;
    cycle("stall write r4");
    check("stall hold 0", d_1, 32'h10);
    we1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle("stall idle");
      check("stall hold", d_1, 32'h10);
    end
    stall = 1'b0;
    cycle("stall release");
    check("stall release d_1", d_1, 32'h20);

    // ret_val follows stored r1
    we1 = 1'b1; target_1 = 5'd1; write_data_1 = 32'h55;
    cycle("write r1");
    check("ret_val r1", ret_val, 32'h55);

    // Reset mid-stall
    idle(); s_1 = 5'd4; s_2 = 5'd1;
    cycle("read before reset");
    check("pre-reset d_2", d_2, 32'h55);
    stall = 1'b1; rst = 1'b1;
    we1 = 1'b1; target_1 = 5'd1; write_data_1 = 32'h77;
    cycle("reset in stall");
    check("reset-stall ret_val", ret_val, 32'h0);
    check("reset-stall d_1", d_1, 32'h0);
    rst = 1'b0; we1 = 1'b0;
    cycle("stall after reset");
    check("post-reset stall d_1", d_1, 32'h0);
    stall = 1'b0;
    cycle("release after reset");

    // Randomized traffic; small target range makes clashes and bypasses common
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      we1          = $urandom_range(0, 1);
      we2          = $urandom_range(0, 1);
      target_1     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      target_2     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      s_1          = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      s_2          = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      write_data_1 = $urandom;
      write_data_2 = $urandom;
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
